instr_fetch: RTL



---
 rtl/instr_fetch_if.sv | 29 ++
 rtl/instr_fetch.sv | 125 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-fetch bus: instruction-memory port plus decoder handshake and status.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] instruction_data;
  logic        instruction_RDY_BSY;
  logic        decoder_rdy_bsy;
  logic [31:0] pc_offset;
  logic        pc_jump_enb;
  logic [31:0] pc_out;
  logic [31:0] fetch_count;
  logic        fetch_err;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instruction_data, instruction_RDY_BSY,
           pc_out, fetch_count, fetch_err,
    input  imem_rdata, imem_valid, decoder_rdy_bsy, pc_offset, pc_jump_enb
  );

  // Memory / decoder side
  modport slave (
    input  imem_req, imem_addr, instruction_data, instruction_RDY_BSY,
           pc_out, fetch_count, fetch_err,
    output imem_rdata, imem_valid, decoder_rdy_bsy, pc_offset, pc_jump_enb
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads imem at pc, offers the word to the decoder,
// waits for execution to finish, then advances pc sequentially or by a jump.
module instr_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned IMEM_TIMEOUT = 16
) (
  input logic          clk,
  input logic          rst,
  instr_fetch_if.master bus
);

  localparam int unsigned TO_W = $clog2(IMEM_TIMEOUT + 1);

  typedef enum logic [1:0] {FETCH, OFFER, EXEC, NEXT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            req_q, req_d;
  logic [31:0]     data_q, data_d;
  logic            rdy_q, rdy_d;
  logic [31:0]     count_q, count_d;
  logic            err_q, err_d;
  logic            jump_q, jump_d;
  logic [31:0]     off_q, off_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [31:0]     sum_c;

  // State and datapath registers; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      data_q  <= 32'h0;
      rdy_q   <= 1'b0;
      count_q <= 32'h0;
      err_q   <= 1'b0;
      jump_q  <= 1'b0;
      off_q   <= 32'h0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      count_q <= count_d;
      err_q   <= err_d;
      jump_q  <= jump_d;
      off_q   <= off_d;
      to_q    <= to_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    count_d = count_q;
    err_d   = err_q;
    jump_d  = jump_q;
    off_d   = off_q;
    to_d    = to_q;
    sum_c   = jump_q ? (pc_q + off_q) : (pc_q + 32'd4);

    unique case (state_q)
      FETCH: begin
        if (!req_q) begin
          // (Re-)issue the request after reset or a timeout gap
          req_d = 1'b1;
        end else if (bus.imem_valid) begin
          data_d  = bus.imem_rdata;
          req_d   = 1'b0;
          rdy_d   = bus.decoder_rdy_bsy;
          to_d    = '0;
          state_d = OFFER;
        end else if (to_q == TO_W'(IMEM_TIMEOUT - 1)) begin
          err_d = 1'b1;
          to_d  = '0;
          req_d = 1'b0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      OFFER: begin
        if (rdy_q && !bus.decoder_rdy_bsy) begin
          // Decoder went busy while offered: instruction accepted
          rdy_d   = 1'b0;
          count_d = count_q + 32'd1;
          state_d = EXEC;
        end else begin
          rdy_d = bus.decoder_rdy_bsy;
        end
      end
      EXEC: begin
        if (bus.pc_jump_enb) begin
          jump_d = 1'b1;
          off_d  = bus.pc_offset;
        end
        if (bus.decoder_rdy_bsy) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        pc_d    = {sum_c[31:2], 2'b00};
        jump_d  = 1'b0;
        req_d   = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  assign bus.imem_req            = req_q;
  assign bus.imem_addr           = pc_q;
  assign bus.instruction_data    = data_q;
  assign bus.instruction_RDY_BSY = rdy_q;
  assign bus.pc_out              = pc_q;
  assign bus.fetch_count         = count_q;
  assign bus.fetch_err           = err_q;

endmodule
